// File: rtl/clk_div_sched.sv
// clk_div_sched: runtime-programmable 50%-duty clock divider (odd and even
// ratios) with a run/drain/stop controller. The ratio and run state change
// only at the end of an output period, so clk_o never shows a runt pulse.
module clk_div_sched #(
    parameter int WIDTH       = 6,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_o,
    output logic             running,
    output logic [WIDTH-1:0] cur_div,
    output logic             switch_done,
    output logic             err
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] cur_div_r;
    logic [WIDTH-1:0] pend_div_r;
    logic [WIDTH-1:0] div_s;
    logic [WIDTH-1:0] half_s;
    logic             pos_hi_r;
    logic             pos_hi_s;
    logic             neg_hi_r;
    logic             pending_r;
    logic             cfg_ready_r;
    logic             switch_done_r;
    logic             err_r;
    logic             running_r;
    logic             tc_s;
    logic             apply_s;
    logic             accept_s;
    logic             cfg_ok_s;

    // Terminal count, handshake decode, ratio selection and next-state logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        tc_s     = (state_r != ST_STOP) && (cnt_r == (cur_div_r - ONE));
        accept_s = cfg_valid & cfg_ready_r;
        cfg_ok_s = (cfg_div >= TWO);
        // A pending ratio lands immediately when stopped, else at period end.
        apply_s  = pending_r & ((state_r == ST_STOP) | tc_s);
        div_s    = apply_s ? pend_div_r : cur_div_r;
        half_s   = div_s >> 1;

        case (state_r)
            ST_STOP: begin
                cnt_s = '0;
                if (en) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_RUN, ST_DRAIN: begin
                // en is only honoured as a stop at the period end; a low en
                // mid-period just marks the period as draining.
                if (tc_s) begin
                    cnt_s   = '0;
                    state_s = en ? ST_RUN : ST_STOP;
                end else begin
                    cnt_s   = cnt_r + ONE;
                    state_s = en ? ST_RUN : ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_STOP;
                cnt_s   = '0;
            end
        endcase

        pos_hi_s = (state_s != ST_STOP) && (cnt_s < half_s);
    end

    // Posedge state: FSM, counter, high-phase flag, ratio and handshake.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_r       <= ST_STOP;
            cnt_r         <= '0;
            pos_hi_r      <= 1'b0;
            cur_div_r     <= DEF_DIV;
            pend_div_r    <= DEF_DIV;
            pending_r     <= 1'b0;
            cfg_ready_r   <= 1'b1;
            switch_done_r <= 1'b0;
            err_r         <= 1'b0;
            running_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            pos_hi_r      <= pos_hi_s;
            cur_div_r     <= div_s;
            switch_done_r <= apply_s;
            err_r         <= accept_s & ~cfg_ok_s;
            running_r     <= (state_s != ST_STOP);
            if (apply_s) begin
                pending_r   <= 1'b0;
                cfg_ready_r <= 1'b1;
            end else if (accept_s & cfg_ok_s) begin
                pend_div_r  <= cfg_div;
                pending_r   <= 1'b1;
                cfg_ready_r <= 1'b0;
            end else begin
                pending_r   <= pending_r;
                cfg_ready_r <= cfg_ready_r;
            end
        end
    end

    // Negedge copy of the high flag; stretches odd ratios by half a cycle.
    always_ff @(negedge clk_i) begin
        if (rst) begin
            neg_hi_r <= 1'b0;
        end else begin
            neg_hi_r <= pos_hi_r;
        end
    end

    assign clk_o       = pos_hi_r | (cur_div_r[0] & neg_hi_r);
    assign cfg_ready   = cfg_ready_r;
    assign running     = running_r;
    assign cur_div     = cur_div_r;
    assign switch_done = switch_done_r;
    assign err         = err_r;

endmodule
